// File: rtl/acc_writeback_if.sv
// acc_writeback_if: SRAM write port (valid/ready) between the drain unit and the SRAM.
interface acc_writeback_if #(
    parameter int ADDR_WIDTH      = 10,
    parameter int SRAM_DATA_WIDTH = 64
);
    logic                       sram_wen;
    logic [ADDR_WIDTH-1:0]      sram_waddr;
    logic [SRAM_DATA_WIDTH-1:0] sram_wdata;
    logic                       sram_wready;

    modport master (
        output sram_wen,
        output sram_waddr,
        output sram_wdata,
        input  sram_wready
    );

    modport slave (
        input  sram_wen,
        input  sram_waddr,
        input  sram_wdata,
        output sram_wready
    );
endinterface

// File: rtl/acc_writeback.sv
// acc_writeback: snapshots the MAC accumulator bus and bursts it into SRAM.
// Define ACC_WB_REQUANT_EN for the int8 round/shift/saturate packing path.
module acc_writeback #(
    parameter int ARRAY_SIZE      = 8,
    parameter int OUTCOME_WIDTH   = 32,
    parameter int SRAM_DATA_WIDTH = 64,
    parameter int ADDR_WIDTH      = 10
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                wb_start,
    input  logic [ADDR_WIDTH-1:0]               base_addr,
    input  logic [4:0]                          shift,
    input  logic [ARRAY_SIZE*OUTCOME_WIDTH-1:0] mul_outcome,
    output logic                                busy,
    output logic                                done,
    acc_writeback_if.master                     wr
);

`ifdef ACC_WB_REQUANT_EN
    localparam int LANE_W = 8;
`else
    localparam int LANE_W = OUTCOME_WIDTH;
`endif
    localparam int SNAP_W = ARRAY_SIZE * LANE_W;
    localparam int NW     = SNAP_W / SRAM_DATA_WIDTH;
    localparam int IDX_W  = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [IDX_W-1:0]           idx_q, idx_d;
    logic [SNAP_W-1:0]          snap_q, snap_d;
    logic                       wen_q, wen_d;
    logic [ADDR_WIDTH-1:0]      waddr_q, waddr_d;
    logic [SRAM_DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [SNAP_W-1:0]          proc;

`ifdef ACC_WB_REQUANT_EN
    localparam int W = OUTCOME_WIDTH + 1;
    localparam logic signed [W-1:0] QMAX = W'(127);
    localparam logic signed [W-1:0] QMIN = -W'(128);

    logic signed [W-1:0] lane, rnd, shf;

    // One extra bit keeps the rounding add from wrapping at the lane maximum.
    always_comb begin
        proc = '0;
        lane = '0;
        rnd  = '0;
        shf  = '0;
        for (int i = 0; i < ARRAY_SIZE; i++) begin
            lane = $signed({mul_outcome[(ARRAY_SIZE-i)*OUTCOME_WIDTH-1],
                            mul_outcome[(ARRAY_SIZE-i)*OUTCOME_WIDTH-1 -: OUTCOME_WIDTH]});
            rnd  = (shift != 5'd0) ? $signed(W'(1) << (shift - 5'd1)) : '0;
            shf  = (lane + rnd) >>> shift;
            if (shf > QMAX)
                proc[(ARRAY_SIZE-i)*8-1 -: 8] = 8'h7f;
            else if (shf < QMIN)
                proc[(ARRAY_SIZE-i)*8-1 -: 8] = 8'h80;
            else
                proc[(ARRAY_SIZE-i)*8-1 -: 8] = shf[7:0];
        end
    end
`else
    logic unused_shift;
    assign unused_shift = ^shift;
    assign proc = mul_outcome;
`endif

    function automatic logic [SRAM_DATA_WIDTH-1:0] word_of(
        input logic [SNAP_W-1:0] s,
        input logic [IDX_W-1:0]  k
    );
        return SRAM_DATA_WIDTH'(s >> ((NW - 1 - int'(k)) * SRAM_DATA_WIDTH));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            snap_q  <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        wen_d   = wen_q;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (wb_start) begin
                    snap_d  = proc;
                    idx_d   = '0;
                    wen_d   = 1'b1;
                    waddr_d = base_addr;
                    wdata_d = word_of(proc, '0);
                    busy_d  = 1'b1;
                    state_d = S_WRITE;
                end
            end
            S_WRITE: begin
                if (wen_q && wr.sram_wready) begin
                    if (idx_q == LAST) begin
                        wen_d   = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        waddr_d = waddr_q + ADDR_WIDTH'(1);
                        wdata_d = word_of(snap_q, idx_q + IDX_W'(1));
                    end
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign wr.sram_wen   = wen_q;
    assign wr.sram_waddr = waddr_q;
    assign wr.sram_wdata = wdata_q;
    assign busy          = busy_q;
    assign done          = done_q;

endmodule

// File: doc/acc_writeback.md
# acc_writeback

Result drain unit for the matrix co-accelerator. On a start pulse it snapshots the packed accumulator bus from the systolic MAC array (`mul_outcome`, lane 0 in the MSBs), and writes it to the output SRAM as a burst of `SRAM_DATA_WIDTH` words under a ready/enable handshake. It is the write-side counterpart of the array's SRAM read feed, and frees the array to clear and restart once the snapshot is taken.

## Interface
- `ARRAY_SIZE`, 8, number of accumulator lanes.
- `OUTCOME_WIDTH`, 32, bits per accumulator lane (signed).
- `SRAM_DATA_WIDTH`, 64, output SRAM word width; must divide `ARRAY_SIZE*OUTCOME_WIDTH` and `ARRAY_SIZE*8`.
- `ADDR_WIDTH`, 10, output SRAM address width.
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high.
- `wb_start`  in  1  single-cycle request; sampled only in IDLE.
- `base_addr`  in  ADDR_WIDTH  first write address; sampled with `wb_start`.
- `shift`  in  5  requant right-shift amount; sampled with `wb_start` (used only with the macro).
- `mul_outcome`  in  ARRAY_SIZE*OUTCOME_WIDTH  packed accumulators; lane i at bits `[(ARRAY_SIZE-i)*OUTCOME_WIDTH-1 -: OUTCOME_WIDTH]`.
- `sram_wready`  in  1  SRAM accepts the current write this cycle.
- `sram_wen`  out  1  write valid.
- `sram_waddr`  out  ADDR_WIDTH  write address.
- `sram_wdata`  out  SRAM_DATA_WIDTH  write data.
- `busy`  out  1  high from the cycle after accepted `wb_start` through the DONE cycle.
- `done`  out  1  one-cycle pulse after the last write is accepted.

## Operation
- FSM: IDLE, WRITE, DONE.
- IDLE with `wb_start`=1:
  - Capture `mul_outcome` (post-processed per Configuration) into the snapshot register.
  - Capture `base_addr`.
  - Clear the word index; go to WRITE.
- IDLE with `wb_start`=0: hold.
- `wb_start` outside IDLE is ignored. It is not queued.
- WRITE:
  - `sram_wen`=1, `sram_waddr` = base + idx, `sram_wdata` = word idx of the snapshot.
  - A write is accepted on a cycle where `sram_wen`&`sram_wready`. On acceptance, idx increments.
  - If the accepted word is the last one (idx = NW-1), go to DONE.
- DONE: `done`=1, `sram_wen`=0; next state IDLE.
- Word packing, raw mode: NW = ARRAY_SIZE*OUTCOME_WIDTH/SRAM_DATA_WIDTH (4 at defaults).
  - Word k holds lanes `2k` in [63:32] and `2k+1` in [31:0]. In general, lanes are MSB-first within and across words.
- Address arithmetic is modulo 2^ADDR_WIDTH. base=1022 with NW=4 writes 1022, 1023, 0, 1.
- Snapshot is immune to `mul_outcome` changes after capture.

## Timing
- All outputs are registered. Reset value of every output is 0: `sram_wen`, `sram_waddr`, `sram_wdata`, `busy`, `done`.
- Reset also forces the FSM to IDLE, idx to 0, and the snapshot to 0.
- Start at edge T:
  - First `sram_wen`=1 in cycle T+1.
  - With `sram_wready` held high, words occupy T+1..T+NW.
  - `done` pulses at T+NW+1.
  - IDLE at T+NW+2; the earliest next `wb_start` is sampled there.
- `sram_wready`=0 in WRITE: `sram_wen`, `sram_waddr` and `sram_wdata` stay stable until accepted. There is no timeout.
- `rst` asserted mid-burst: outputs drop to 0 immediately (asynchronously). No `done` is produced, and the burst is abandoned.
- `wb_start` in the same cycle as `done`: ignored.

## Configuration
- `ACC_WB_REQUANT_EN` defined:
  - At capture, each lane is arithmetic-right-shifted by `shift` with round-half-up. If `shift`>0, add `1<<(shift-1)` before shifting, computed at OUTCOME_WIDTH+1 bits so it cannot overflow.
  - The result is then saturated to signed 8-bit [-128,127].
  - Lanes are packed MSB-first as int8, so NW = ARRAY_SIZE*8/SRAM_DATA_WIDTH (1 at defaults). Lane 0 is at [63:56].
  - Latency rules are unchanged.
- Not defined: the raw 32-bit path above. `shift` is unused, and no requant/saturation logic is synthesized.

## Test plan
- Raw mode, lanes 0..7 = 1..8, base=16, wready=1, `wb_start` at T -> writes {addr16: 0x00000001_00000002, 17: 0x3_4, 18: 0x5_6, 19: 0x7_8} at T+1..T+4, `done` at T+5, `busy` T+1..T+5.
- Raw mode, wready low for 3 cycles during word 1 -> word 1 held stable (addr and data) for 3 cycles; `done` delayed by exactly 3 cycles; no duplicate or skipped addresses.
- Address wrap, base=1022, raw -> addresses 1022, 1023, 0, 1.
- Requant, shift=4, lanes {40, -40, 4096, -4096, 7, 8, -8, 0} -> single write 0x03_FE_7F_80_00_01_00_00 at T+1, `done` at T+2.
  - Per-lane results: 40→3, -40→-2 (round-half-up on -2.5), 4096→127 (saturated), -4096→-128 (saturated), 7→0, 8→1, -8→0 (round-half-up on -0.5), 0→0.
- `mul_outcome` changed and `wb_start` re-pulsed during a burst -> original snapshot written unchanged, second start ignored.
- `rst` asserted at the 2nd write -> all outputs 0 the same cycle; after release, a new `wb_start` performs a full, correct burst.
